// File: rtl/flags_ctrl.sv
// Z/V/N condition-flag register with ALU/interrupt arbitration, a LIFO shadow
// stack for nested interrupts, and registered branch-condition evaluation.
module flags_ctrl #(
  parameter int DEPTH = 4,
  parameter int DW    = 3,
  localparam int AW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          alu_we,
  input  logic [DW-1:0] alu_flags,
  input  logic          int_entry,
  input  logic          int_return,
  input  logic          br_eval,
  input  logic [2:0]    br_cc,
  input  logic          err_clr,
  output logic [DW-1:0] flags_q,
  output logic          br_taken,
  output logic          br_valid,
  output logic [AW-1:0] depth,
  output logic          stack_ovf,
  output logic          stack_unf
);

  logic [DW-1:0] flags_reg, flags_next;
  logic [DW-1:0] stack_reg [DEPTH];
  logic [AW-1:0] depth_reg, depth_next;
  logic          br_taken_reg, br_taken_next;
  logic          br_valid_reg, br_valid_next;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;
  logic [DW-1:0] top;
  logic [DEPTH-1:0] wr_en;
  logic          push, swap, ovf_set, unf_set;
  logic          empty, full, cond, lt;

  assign empty = (depth_reg == '0);
  assign full  = (depth_reg == AW'(DEPTH));

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_reg == AW'(i + 1)) top = stack_reg[i];
    end
  end

  // Interrupt swap/return/entry outrank the ALU; a push flushes the ALU write.
  always_comb begin
    flags_next = flags_reg;
    depth_next = depth_reg;
    push       = 1'b0;
    swap       = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (!stall) begin
      if (int_entry && int_return) begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          swap       = 1'b1;
          flags_next = top;
        end
      end else if (int_return) begin
        if (empty) begin
          unf_set = 1'b1;
          if (alu_we) flags_next = alu_flags;
        end else begin
          flags_next = top;
          depth_next = depth_reg - 1'b1;
        end
      end else if (int_entry) begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          push       = 1'b1;
          depth_next = depth_reg + 1'b1;
        end
      end else if (alu_we) begin
        flags_next = alu_flags;
      end
    end
  end

  // Branch condition sees the flags being written this cycle.
  assign lt = flags_next[0] ^ flags_next[1];

  always_comb begin
    cond = 1'b0;
    case (br_cc)
      3'b000:  cond = ~flags_next[2];
      3'b001:  cond = flags_next[2];
      3'b010:  cond = ~flags_next[2] & ~lt;
      3'b011:  cond = lt;
      3'b100:  cond = ~lt;
      3'b101:  cond = flags_next[2] | lt;
      3'b110:  cond = flags_next[1];
      default: cond = 1'b1;
    endcase
  end

  assign br_valid_next = br_eval & ~stall;
  assign br_taken_next = br_valid_next ? cond : br_taken_reg;
  assign ovf_next      = ovf_set | (ovf_reg & ~err_clr);
  assign unf_next      = unf_set | (unf_reg & ~err_clr);

  // Push writes the slot at depth; swap overwrites the current top.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
      assign wr_en[gi] = (push && (depth_reg == AW'(gi))) ||
                         (swap && (depth_reg == AW'(gi + 1)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stack_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) stack_reg[i] <= flags_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg    <= '0;
      depth_reg    <= '0;
      br_taken_reg <= 1'b0;
      br_valid_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
    end else begin
      flags_reg    <= flags_next;
      depth_reg    <= depth_next;
      br_taken_reg <= br_taken_next;
      br_valid_reg <= br_valid_next;
      ovf_reg      <= ovf_next;
      unf_reg      <= unf_next;
    end
  end

  assign flags_q   = flags_reg;
  assign depth     = depth_reg;
  assign br_taken  = br_taken_reg;
  assign br_valid  = br_valid_reg;
  assign stack_ovf = ovf_reg;
  assign stack_unf = unf_reg;

endmodule

// File: tb/tb_flags_ctrl.sv
// Bench for flags_ctrl: directed vector table, stall/reset sequence, then
// randomized traffic checked against a queue-based reference model.
module tb_flags_ctrl;
  localparam int DEPTH = 4;

  logic       clk, rst_n, stall, alu_we, int_entry, int_return, br_eval, err_clr;
  logic [2:0] alu_flags, br_cc, flags_q, depth;
  logic       br_taken, br_valid, stack_ovf, stack_unf;

  flags_ctrl #(.DEPTH(DEPTH), .DW(3)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .alu_we(alu_we), .alu_flags(alu_flags),
    .int_entry(int_entry), .int_return(int_return), .br_eval(br_eval), .br_cc(br_cc),
    .err_clr(err_clr), .flags_q(flags_q), .br_taken(br_taken), .br_valid(br_valid),
    .depth(depth), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       we; logic [2:0] af; logic ie, ir, be; logic [2:0] cc; logic ec;
    logic [2:0] ef; logic [2:0] ed; logic et, ev, eo, eu;
  } vec_t;
  vec_t vecs[$];

  int total = 0;
  int passed = 0;

  // Reference model state: flags plus a LIFO queue of saved flags.
  logic [2:0] m_flags;
  logic [2:0] m_stk[$];
  logic       m_taken, m_valid, m_ovf, m_unf;

  task automatic add(input logic we, input logic [2:0] af, input logic ie, ir, be,
                     input logic [2:0] cc, input logic ec, input logic [2:0] ef,
                     input logic [2:0] ed, input logic et, ev, eo, eu);
    vec_t v;
    v.we = we; v.af = af; v.ie = ie; v.ir = ir; v.be = be; v.cc = cc; v.ec = ec;
    v.ef = ef; v.ed = ed; v.et = et; v.ev = ev; v.eo = eo; v.eu = eu;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] ef, input logic [2:0] ed,
                       input logic et, ev, eo, eu);
    total++;
    if ({flags_q, depth, br_taken, br_valid, stack_ovf, stack_unf} === {ef, ed, et, ev, eo, eu}) begin
      passed++;
      $display("ok   %s flags=%b depth=%0d taken=%b valid=%b ovf=%b unf=%b",
               name, flags_q, depth, br_taken, br_valid, stack_ovf, stack_unf);
    end else begin
      $display("FAIL %s: got flags=%b depth=%0d taken=%b valid=%b ovf=%b unf=%b, expected flags=%b depth=%0d taken=%b valid=%b ovf=%b unf=%b",
               name, flags_q, depth, br_taken, br_valid, stack_ovf, stack_unf,
               ef, ed, et, ev, eo, eu);
    end
  endtask

  task automatic drive(input logic st, we, input logic [2:0] af, input logic ie, ir, be,
                       input logic [2:0] cc, input logic ec);
    stall = st; alu_we = we; alu_flags = af; int_entry = ie; int_return = ir;
    br_eval = be; br_cc = cc; err_clr = ec;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cc_eval(input logic [2:0] cc, input logic [2:0] f);
    logic z, v, n, l;
    z = f[2]; v = f[1]; n = f[0]; l = n ^ v;
    case (cc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !l;
      3'd3: return l;
      3'd4: return !l;
      3'd5: return z || l;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // One cycle of the reference behaviour, evaluated on the inputs currently driven.
  task automatic model_step();
    logic [2:0] nf;
    logic os, us;
    nf = m_flags; os = 1'b0; us = 1'b0;
    if (!stall) begin
      if (int_entry && int_return) begin
        if (m_stk.size() == 0) us = 1'b1;
        else begin nf = m_stk.pop_back(); m_stk.push_back(m_flags); end
      end else if (int_return) begin
        if (m_stk.size() == 0) begin us = 1'b1; if (alu_we) nf = alu_flags; end
        else nf = m_stk.pop_back();
      end else if (int_entry) begin
        if (m_stk.size() == DEPTH) os = 1'b1;
        else m_stk.push_back(m_flags);
      end else if (alu_we) nf = alu_flags;
      if (br_eval) m_taken = cc_eval(br_cc, nf);
    end
    m_valid = br_eval && !stall;
    m_flags = nf;
    m_ovf = os || (m_ovf && !err_clr);
    m_unf = us || (m_unf && !err_clr);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 3'b000, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    //  we  af     ie ir be cc     ec   flags  d  tk vl ov un
    add(1, 3'b100, 0, 0, 1, 3'b001, 0,  3'b100, 0, 1, 1, 0, 0);
    add(0, 3'b000, 0, 0, 0, 3'b000, 0,  3'b100, 0, 1, 0, 0, 0);
    add(1, 3'b010, 0, 0, 0, 3'b000, 0,  3'b010, 0, 1, 0, 0, 0);
    add(1, 3'b001, 0, 0, 1, 3'b011, 0,  3'b001, 0, 1, 1, 0, 0);
    add(1, 3'b010, 0, 0, 0, 3'b000, 0,  3'b010, 0, 1, 0, 0, 0);
    add(1, 3'b001, 0, 0, 1, 3'b100, 0,  3'b001, 0, 0, 1, 0, 0);
    add(0, 3'b000, 1, 0, 0, 3'b000, 0,  3'b001, 1, 0, 0, 0, 0);
    add(1, 3'b010, 0, 0, 0, 3'b000, 0,  3'b010, 1, 0, 0, 0, 0);
    add(0, 3'b000, 1, 0, 0, 3'b000, 0,  3'b010, 2, 0, 0, 0, 0);
    add(1, 3'b100, 0, 0, 0, 3'b000, 0,  3'b100, 2, 0, 0, 0, 0);
    add(0, 3'b000, 1, 0, 0, 3'b000, 0,  3'b100, 3, 0, 0, 0, 0);
    add(1, 3'b011, 0, 0, 0, 3'b000, 0,  3'b011, 3, 0, 0, 0, 0);
    add(0, 3'b000, 1, 0, 0, 3'b000, 0,  3'b011, 4, 0, 0, 0, 0);
    add(1, 3'b111, 1, 0, 0, 3'b000, 0,  3'b011, 4, 0, 0, 1, 0);
    add(0, 3'b000, 0, 1, 0, 3'b000, 0,  3'b011, 3, 0, 0, 1, 0);
    add(0, 3'b000, 0, 1, 0, 3'b000, 0,  3'b100, 2, 0, 0, 1, 0);
    add(0, 3'b000, 0, 1, 0, 3'b000, 0,  3'b010, 1, 0, 0, 1, 0);
    add(0, 3'b000, 0, 1, 0, 3'b000, 0,  3'b001, 0, 0, 0, 1, 0);
    add(0, 3'b000, 0, 1, 0, 3'b000, 0,  3'b001, 0, 0, 0, 1, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 1,  3'b001, 0, 0, 0, 0, 0);
    add(1, 3'b010, 0, 0, 0, 3'b000, 0,  3'b010, 0, 0, 0, 0, 0);
    add(1, 3'b111, 1, 0, 0, 3'b000, 0,  3'b010, 1, 0, 0, 0, 0);
    add(1, 3'b000, 0, 1, 0, 3'b000, 0,  3'b010, 0, 0, 0, 0, 0);
    add(1, 3'b100, 0, 0, 0, 3'b000, 0,  3'b100, 0, 0, 0, 0, 0);
    add(0, 3'b000, 1, 0, 0, 3'b000, 0,  3'b100, 1, 0, 0, 0, 0);
    add(1, 3'b001, 0, 0, 0, 3'b000, 0,  3'b001, 1, 0, 0, 0, 0);
    add(0, 3'b000, 1, 1, 0, 3'b000, 0,  3'b100, 1, 0, 0, 0, 0);
    add(0, 3'b000, 0, 1, 0, 3'b000, 0,  3'b001, 0, 0, 0, 0, 0);
    add(0, 3'b000, 1, 1, 0, 3'b000, 0,  3'b001, 0, 0, 0, 0, 1);
    add(1, 3'b110, 0, 1, 0, 3'b000, 0,  3'b110, 0, 0, 0, 0, 1);
    add(0, 3'b000, 0, 1, 0, 3'b000, 1,  3'b110, 0, 0, 0, 0, 1);
    add(0, 3'b000, 0, 0, 0, 3'b000, 1,  3'b110, 0, 0, 0, 0, 0);
    add(0, 3'b000, 1, 0, 0, 3'b000, 0,  3'b110, 1, 0, 0, 0, 0);
    add(1, 3'b000, 0, 0, 1, 3'b000, 0,  3'b000, 1, 1, 1, 0, 0);
    add(0, 3'b000, 0, 1, 1, 3'b010, 0,  3'b110, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      drive(0, vecs[i].we, vecs[i].af, vecs[i].ie, vecs[i].ir, vecs[i].be, vecs[i].cc, vecs[i].ec);
      tick();
      check($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ed, vecs[i].et, vecs[i].ev,
            vecs[i].eo, vecs[i].eu);
    end

    // Stall holds everything except err_clr; reset mid-stall clears at once.
    drive(0, 0, 3'b000, 0, 1, 1, 3'b111, 0);
    tick();
    check("pre_stall", 3'b110, 0, 1, 1, 0, 1);
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 3'b001, 1, 0, 1, 3'b000, (c == 2));
      tick();
      check($sformatf("stall%0d", c), 3'b110, 0, 1, 0, 0, (c != 2));
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset", 3'b000, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("post_reset", 3'b000, 0, 0, 0, 0, 0);

    m_flags = 3'b000; m_stk = {}; m_taken = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 99) < 10, $urandom_range(0, 1), 3'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 22, $urandom_range(0, 99) < 20,
            $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 99) < 5);
      model_step();
      tick();
      check($sformatf("rand%0d", n), m_flags, 3'(m_stk.size()), m_taken, m_valid, m_ovf, m_unf);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
